irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Reset is asynchronous and active-high; one clock; ports clk and rst.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 clk_en  input  1  clock enable; state (except reset) advances only when high.
REQ-005 cs  input  1  chip select, decoded externally from CPU address.
REQ-006 addr  input  3  register index (CPU address bits 2:0).
REQ-007 rw  input  1  CPU bus direction: 1 = read, 0 = write.
REQ-008 ph2  input  1  CPU phase-2 indicator; write data is valid while high.
REQ-009 data_i  input  8  CPU write data.
REQ-010 data_o  output  8  register read data; combinational from addr, 0x00 when cs low.
REQ-011 src  input  8  interrupt sources, active-high, asynchronous to clk.
REQ-012 irq_n  output  1  registered active-low level interrupt to CPU.
REQ-013 nmi_n  output  1  registered active-low watchdog NMI to CPU.

Function
REQ-014 Each src bit passes through a 2-flop synchronizer clocked on clk_en; logic uses only synchronized bits.
REQ-015 Register write strobe = cs & ~rw & ph2 & clk_en; write takes effect on that clock edge.
REQ-016 addr 0 STATUS: read = pending[7:0]; write-1-to-clear per bit.
REQ-017 addr 1 MASK: read/write; 1 enables the source.
REQ-018 addr 2 EDGE: read/write; 1 = rising-edge triggered, 0 = level.
REQ-019 addr 3 VECTOR: read-only; bit7 = 1 when no enabled pending source, else bits2:0 = lowest-numbered enabled pending bit and bits6:3 = 0; writes ignored.
REQ-020 Edge source: pending bit set on a synchronized 0->1 transition; held until cleared by W1C.
REQ-021 Level source: pending bit equals the synchronized level each enabled cycle; W1C has no lasting effect.
REQ-022 Same-cycle edge and W1C on one bit: set wins; pending stays 1.
REQ-023 Pending bits latch regardless of MASK; MASK gates only irq_n and VECTOR.
REQ-024 Changing EDGE for a bit clears that bit's pending and edge history in the same cycle.
REQ-025 irq_n is registered: it goes low one clk_en cycle after (pending & mask) becomes nonzero, and high one clk_en cycle after it becomes zero.
REQ-026 Total latency from a src rising edge to irq_n low is 4 clk_en cycles: 2 synchronizer, 1 pending, 1 irq_n.
REQ-027 When clk_en is low, all registers hold and irq_n/nmi_n hold.

Reset
REQ-028 On rst, pending, MASK and EDGE are 0x00.
REQ-029 On rst, synchronizer flops and edge history are 0.
REQ-030 On rst, irq_n = 1, nmi_n = 1, and watchdog counter = 0xFFFF with the watchdog disabled.
REQ-031 rst asserted mid-operation aborts any NMI pulse immediately: nmi_n = 1.

Configuration
REQ-032 Macro IRQC_WDT_EN: when defined, a 16-bit watchdog is built in.
  - addr 4/5: reload low/high, read/write.
  - addr 6: write of any value kicks the watchdog, reloads the counter and sets enable.
  - addr 7: read returns counter high byte.
  - The counter decrements each clk_en cycle while enabled.
  - When the counter reaches 0, nmi_n is driven low for exactly 8 clk_en cycles, then the counter auto-reloads.
  - A kick during the pulse ends the pulse next cycle.
REQ-033 Without IRQC_WDT_EN: nmi_n is constant 1, addr 4-7 read 0x00, and writes to them are ignored.

Verification
REQ-034 MASK=0x01, EDGE=0x01, pulse src[0] for 1 cycle -> irq_n low 4 cycles later, STATUS=0x01, VECTOR=0x00; write STATUS 0x01 -> irq_n high next cycle.
REQ-035 EDGE=0x00, MASK=0x80, hold src[7] high -> VECTOR=0x07; W1C STATUS 0x80 -> STATUS still 0x80; drop src[7] -> STATUS=0x00 after 3 cycles and irq_n high after 4.
REQ-036 MASK=0x00, edge on src[3] -> STATUS=0x08, irq_n stays 1, VECTOR=0x80; then write MASK=0x08 -> irq_n low next cycle.
REQ-037 src[2] edge coincident with W1C 0x04 -> STATUS bit2 stays 1; src[1] and src[5] pending with MASK=0xFF -> VECTOR=0x01.
REQ-038 Requires IRQC_WDT_EN: reload 0x0010, kick -> nmi_n low after 17 clk_en cycles for exactly 8 cycles; a kick every 10 cycles -> nmi_n never low.
REQ-039 Assert rst during the NMI pulse and while irq_n is low -> nmi_n=1, irq_n=1, MASK/EDGE/STATUS read 0x00.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// CPU register bus for irq_ctrl: chip select, index, direction, phase-2 strobe and data.
// The CPU drives the master side; irq_ctrl answers on the slave side.
interface irq_ctrl_if;
   logic       cs;
   logic [2:0] addr;
   logic       rw;
   logic       ph2;
   logic [7:0] data_i;
   logic [7:0] data_o;

   modport master (
      output cs,
      output addr,
      output rw,
      output ph2,
      output data_i,
      input  data_o
   );

   modport slave (
      input  cs,
      input  addr,
      input  rw,
      input  ph2,
      input  data_i,
      output data_o
   );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source interrupt controller (STATUS/MASK/EDGE/VECTOR), optional watchdog NMI when IRQC_WDT_EN is defined.
// Latency src->irq_n is 4 clk_en cycles; no backpressure, clk_en low freezes all state.
module irq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic [7:0] src,
   output logic       irq_n,
   output logic       nmi_n,
   irq_ctrl_if.slave  bus
);

   localparam logic [2:0] A_STATUS = 3'd0;
   localparam logic [2:0] A_MASK   = 3'd1;
   localparam logic [2:0] A_EDGE   = 3'd2;
   localparam logic [2:0] A_VECTOR = 3'd3;

   logic       wr_stb;
   logic [7:0] sync1;
   logic [7:0] sync2;
   logic [7:0] hist;
   logic [7:0] pending;
   logic [7:0] mask;
   logic [7:0] edge_sel;
   logic [7:0] w1c;
   logic [7:0] edge_chg;
   logic [7:0] rise;
   logic [7:0] pending_nxt;
   logic [7:0] active;
   logic [7:0] vector;
   logic [7:0] rd_dat;
   logic [7:0] wdt_rd;

   assign wr_stb = bus.cs & ~bus.rw & bus.ph2 & clk_en;
   assign active = pending & mask;

   always_comb begin
      w1c         = (wr_stb && bus.addr == A_STATUS) ? bus.data_i : 8'h00;
      edge_chg    = (wr_stb && bus.addr == A_EDGE) ? (bus.data_i ^ edge_sel) : 8'h00;
      rise        = sync2 & ~hist;
      pending_nxt = 8'h00;
      // Mode change wipes the bit; an edge beats a same-cycle W1C; level bits mirror the input.
      for (int i = 0; i < 8; i++) begin
         if (edge_chg[i])
            pending_nxt[i] = 1'b0;
         else if (edge_sel[i])
            pending_nxt[i] = rise[i] | (pending[i] & ~w1c[i]);
         else
            pending_nxt[i] = sync2[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 8'h00;
         sync2    <= 8'h00;
         hist     <= 8'h00;
         pending  <= 8'h00;
         mask     <= 8'h00;
         edge_sel <= 8'h00;
         irq_n    <= 1'b1;
      end else if (clk_en) begin
         sync1   <= src;
         sync2   <= sync1;
         hist    <= sync2 & ~edge_chg;
         pending <= pending_nxt;
         irq_n   <= ~|active;
         if (wr_stb && bus.addr == A_MASK)
            mask <= bus.data_i;
         if (wr_stb && bus.addr == A_EDGE)
            edge_sel <= bus.data_i;
      end
   end

   always_comb begin
      vector = 8'h80;
      for (int i = 7; i >= 0; i--) begin
         if (active[i])
            vector = 8'(i);
      end
   end

   always_comb begin
      rd_dat = 8'h00;
      case (bus.addr)
         A_STATUS: rd_dat = pending;
         A_MASK:   rd_dat = mask;
         A_EDGE:   rd_dat = edge_sel;
         A_VECTOR: rd_dat = vector;
         default:  rd_dat = wdt_rd;
      endcase
   end

   assign bus.data_o = bus.cs ? rd_dat : 8'h00;

`ifdef IRQC_WDT_EN
   localparam logic [2:0] A_RLD_LO = 3'd4;
   localparam logic [2:0] A_RLD_HI = 3'd5;
   localparam logic [2:0] A_KICK   = 3'd6;
   localparam logic [2:0] A_CNT_HI = 3'd7;

   typedef enum logic [1:0] {
      WDT_OFF,
      WDT_RUN,
      WDT_NMI
   } wdt_state_t;

   wdt_state_t  state;
   wdt_state_t  state_nxt;
   logic [15:0] reload;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic [2:0]  pulse;
   logic [2:0]  pulse_nxt;
   logic        kick;

   assign kick = wr_stb && bus.addr == A_KICK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= WDT_OFF;
         cnt    <= 16'hFFFF;
         pulse  <= 3'd0;
         reload <= 16'hFFFF;
         nmi_n  <= 1'b1;
      end else if (clk_en) begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pulse <= pulse_nxt;
         nmi_n <= (state_nxt != WDT_NMI);
         if (wr_stb && bus.addr == A_RLD_LO)
            reload[7:0] <= bus.data_i;
         if (wr_stb && bus.addr == A_RLD_HI)
            reload[15:8] <= bus.data_i;
      end
   end

   // Counter sits at zero during the 8-cycle pulse and reloads as the pulse ends.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = pulse;
      case (state)
         WDT_OFF: begin
            if (kick) begin
               state_nxt = WDT_RUN;
               cnt_nxt   = reload;
            end
         end
         WDT_RUN: begin
            if (kick) begin
               cnt_nxt = reload;
            end else if (cnt == 16'd0) begin
               state_nxt = WDT_NMI;
               pulse_nxt = 3'd0;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         WDT_NMI: begin
            if (kick || pulse == 3'd7) begin
               state_nxt = WDT_RUN;
               cnt_nxt   = reload;
            end else begin
               pulse_nxt = pulse + 3'd1;
            end
         end
         default: state_nxt = WDT_OFF;
      endcase
   end

   always_comb begin
      wdt_rd = 8'h00;
      case (bus.addr)
         A_RLD_LO: wdt_rd = reload[7:0];
         A_RLD_HI: wdt_rd = reload[15:8];
         A_CNT_HI: wdt_rd = cnt[15:8];
         default:  wdt_rd = 8'h00;
      endcase
   end
`else
   assign nmi_n  = 1'b1;
   assign wdt_rd = 8'h00;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized + directed bench for irq_ctrl against a per-bit behavioural model of the register rules.
module tb_irq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       clk_en;
   logic [7:0] src;
   logic       irq_n;
   logic       nmi_n;

   irq_ctrl_if bus();

   irq_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .src    (src),
      .irq_n  (irq_n),
      .nmi_n  (nmi_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_nmi     = 1'b1;

   logic [7:0] m_pend;
   logic [7:0] m_mask;
   logic [7:0] m_edge;
   logic [7:0] m_hist;
   logic [7:0] m_sync;
   logic [7:0] m_q[$];
   logic       m_irq_n;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pend  = 8'h00;
      m_mask  = 8'h00;
      m_edge  = 8'h00;
      m_hist  = 8'h00;
      m_sync  = 8'h00;
      m_q     = {8'h00};
      m_irq_n = 1'b1;
   endfunction

   function automatic logic [7:0] m_vector();
      logic [7:0] a;
      a = m_pend & m_mask;
      for (int i = 0; i < 8; i++)
         if (a[i]) return 8'(i);
      return 8'h80;
   endfunction

   function automatic logic [7:0] m_reg(input logic [2:0] a);
      case (a)
         3'd0:    return m_pend;
         3'd1:    return m_mask;
         3'd2:    return m_edge;
         3'd3:    return m_vector();
         default: return 8'h00;
      endcase
   endfunction

   // One clock: the model applies the register rules to the inputs the DUT saw at this edge.
   task automatic tick();
      logic       wr;
      logic [7:0] w1c, chg, rise, np;
      @(posedge clk);
      if (clk_en && !rst) begin
         wr   = bus.cs && !bus.rw && bus.ph2;
         w1c  = (wr && bus.addr == 3'd0) ? bus.data_i : 8'h00;
         chg  = (wr && bus.addr == 3'd2) ? (bus.data_i ^ m_edge) : 8'h00;
         rise = m_sync & ~m_hist;
         np   = 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (chg[i])         np[i] = 1'b0;
            else if (m_edge[i]) np[i] = rise[i] || (m_pend[i] && !w1c[i]);
            else                np[i] = m_sync[i];
         end
         m_irq_n = ((m_pend & m_mask) == 8'h00);
         m_hist  = m_sync & ~chg;
         m_sync  = m_q.pop_front();
         m_q.push_back(src);
         m_pend  = np;
         if (wr && bus.addr == 3'd1) m_mask = bus.data_i;
         if (wr && bus.addr == 3'd2) m_edge = bus.data_i;
      end
      #1;
      check("irq_n", 16'(irq_n), 16'(m_irq_n));
      if (chk_nmi) check("nmi_n", 16'(nmi_n), 16'd1);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      bus.cs = 1'b1; bus.rw = 1'b0; bus.ph2 = 1'b1; bus.addr = a; bus.data_i = d;
      tick();
      bus.cs = 1'b0; bus.ph2 = 1'b0; bus.rw = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
      bus.cs = 1'b1; bus.rw = 1'b1; bus.ph2 = 1'b0; bus.addr = a;
      #1;
      check(tag, 16'(bus.data_o), 16'(exp));
      bus.cs = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n;
      logic [2:0] a;
      rst = 1'b1; clk_en = 1'b1; src = 8'h00;
      bus.cs = 1'b0; bus.rw = 1'b1; bus.ph2 = 1'b0; bus.addr = 3'd0; bus.data_i = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_irq_n", 16'(irq_n), 16'd1);
      check("rst_nmi_n", 16'(nmi_n), 16'd1);
      rd(3'd0, 8'h00, "rst_status");
      rd(3'd1, 8'h00, "rst_mask");
      rd(3'd2, 8'h00, "rst_edge");
      rd(3'd3, 8'h80, "rst_vector");
      rst = 1'b0;

      for (int k = 0; k < 1500; k++) begin
         clk_en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) src = 8'($urandom);
         if ($urandom_range(0, 9) < 2) begin
            wr(3'($urandom_range(0, 3)), 8'($urandom));
         end else begin
            a = 3'($urandom_range(0, 3));
            rd(a, m_reg(a), "rand_rd");
            tick();
         end
      end
      clk_en = 1'b1; src = 8'h00;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      model_reset();

      // Edge source: one-cycle pulse, 4-cycle latency, W1C release.
      wr(3'd1, 8'h01);
      wr(3'd2, 8'h01);
      src = 8'h01; tick();
      src = 8'h00; ticks(2);
      check("e_irq_wait", 16'(irq_n), 16'd1);
      tick();
      check("e_irq_low", 16'(irq_n), 16'd0);
      rd(3'd0, 8'h01, "e_status");
      rd(3'd3, 8'h00, "e_vector");
      wr(3'd0, 8'h01);
      tick();
      check("e_irq_clr", 16'(irq_n), 16'd1);

      // Level source: W1C has no lasting effect; release follows the input.
      wr(3'd2, 8'h00);
      wr(3'd1, 8'h80);
      src = 8'h80; ticks(3);
      rd(3'd3, 8'h07, "l_vector");
      tick();
      check("l_irq_low", 16'(irq_n), 16'd0);
      wr(3'd0, 8'h80);
      rd(3'd0, 8'h80, "l_w1c");
      src = 8'h00; ticks(2);
      rd(3'd0, 8'h80, "l_hold2");
      tick();
      rd(3'd0, 8'h00, "l_drop3");
      check("l_irq_still", 16'(irq_n), 16'd0);
      tick();
      check("l_irq_high4", 16'(irq_n), 16'd1);

      // Masked pending, then unmask.
      wr(3'd1, 8'h00);
      wr(3'd2, 8'h08);
      src = 8'h08; tick();
      src = 8'h00; ticks(3);
      rd(3'd0, 8'h08, "m_status");
      rd(3'd3, 8'h80, "m_vector");
      check("m_irq_off", 16'(irq_n), 16'd1);
      wr(3'd1, 8'h08);
      tick();
      check("m_irq_low", 16'(irq_n), 16'd0);
      bus.addr = 3'd0; #1;
      check("cs_low_dat", 16'(bus.data_o), 16'd0);

      // clk_en low: writes and source changes are ignored.
      clk_en = 1'b0; src = 8'hFF;
      wr(3'd0, 8'h08);
      ticks(3);
      src = 8'h00; clk_en = 1'b1;
      rd(3'd0, 8'h08, "ce_status");
      check("ce_irq", 16'(irq_n), 16'd0);

      // Edge coincident with W1C; lowest pending wins the vector.
      wr(3'd0, 8'hFF);
      wr(3'd2, 8'h2E);
      wr(3'd1, 8'hFF);
      src = 8'h04; tick();
      src = 8'h00; tick();
      wr(3'd0, 8'h04);
      rd(3'd0, 8'h04, "c_set_wins");
      src = 8'h22; tick();
      src = 8'h00; ticks(2);
      rd(3'd0, 8'h26, "c_status");
      rd(3'd3, 8'h01, "c_vector");
      tick();
      check("c_irq_low", 16'(irq_n), 16'd0);

`ifdef IRQC_WDT_EN
      chk_nmi = 1'b0;
      wr(3'd4, 8'h10);
      wr(3'd5, 8'h00);
      rd(3'd4, 8'h10, "w_rld_lo");
      rd(3'd5, 8'h00, "w_rld_hi");
      wr(3'd6, 8'h00);
      n = 0;
      while (nmi_n !== 1'b0 && n < 40) begin tick(); n++; end
      check("w_first_nmi", 16'(n), 16'd17);
      n = 0;
      while (nmi_n === 1'b0 && n < 20) begin tick(); n++; end
      check("w_pulse_len", 16'(n), 16'd8);
      wr(3'd5, 8'h12);
      wr(3'd4, 8'h34);
      wr(3'd6, 8'h00);
      rd(3'd7, 8'h12, "w_cnt_hi");
      wr(3'd5, 8'h00);
      wr(3'd4, 8'h10);
      n = 0;
      for (int r = 0; r < 6; r++) begin
         wr(3'd6, 8'h00);
         for (int j = 0; j < 9; j++) begin
            tick();
            if (nmi_n === 1'b0) n++;
         end
      end
      check("w_kicked_lows", 16'(n), 16'd0);
      n = 0;
      while (nmi_n !== 1'b0 && n < 40) begin tick(); n++; end
      check("w_expire", 16'(nmi_n), 16'd0);
      wr(3'd6, 8'h00);
      check("w_kick_ends", 16'(nmi_n), 16'd1);
      wr(3'd4, 8'h04);
      wr(3'd6, 8'h00);
      n = 0;
      while (nmi_n !== 1'b0 && n < 20) begin tick(); n++; end
      check("w_pre_rst_nmi", 16'(nmi_n), 16'd0);
`else
      wr(3'd4, 8'hAA);
      wr(3'd5, 8'h55);
      wr(3'd6, 8'h01);
      wr(3'd7, 8'h03);
      ticks(20);
      for (int r = 4; r < 8; r++) rd(3'(r), 8'h00, "nowdt_rd");
      check("nowdt_nmi", 16'(nmi_n), 16'd1);
`endif

      // Asynchronous reset mid-cycle with irq_n (and NMI when built) active.
      check("pre_rst_irq", 16'(irq_n), 16'd0);
      #2 rst = 1'b1;
      #1;
      check("arst_irq_n", 16'(irq_n), 16'd1);
      check("arst_nmi_n", 16'(nmi_n), 16'd1);
      rd(3'd0, 8'h00, "arst_status");
      rd(3'd1, 8'h00, "arst_mask");
      rd(3'd2, 8'h00, "arst_edge");
      rd(3'd3, 8'h80, "arst_vector");
      rst = 1'b0;
      model_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
